// File: rtl/not_ops.sv
// ---------------------------------------------------------------------------
// not_ops
//   Logic-class ALU unit computing the bitwise NOT of a WIDTH-bit operand.
//   A combinational result (c, zero) feeds the ALU datapath mux directly,
//   and a registered copy with a valid strobe plus sign and parity flags
//   serves pipelined consumers.
//
// Ports
//   clk        in   1      clock, registers update on the rising edge
//   rst        in   1      synchronous active-high reset
//   a          in   WIDTH  operand
//   in_valid   in   1      operand is valid this cycle (registered path only)
//   c          out  WIDTH  combinational ~a
//   zero       out  1      combinational, high iff c is all zeros
//   c_q        out  WIDTH  registered ~a
//   zero_q     out  1      registered zero flag
//   neg_q      out  1      registered sign bit of the result
//   par_q      out  1      registered XOR-reduction of the result
//   out_valid  out  1      registered outputs hold a new result this cycle
// ---------------------------------------------------------------------------
module not_ops #(
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic             in_valid,
  output logic [WIDTH-1:0] c,
  output logic             zero,
  output logic [WIDTH-1:0] c_q,
  output logic             zero_q,
  output logic             neg_q,
  output logic             par_q,
  output logic             out_valid
);

  // Combinational result path. It ignores clk, rst and in_valid so the ALU
  // mux always sees the current operand; unknown bits on a propagate.
  assign c    = ~a;
  assign zero = ~|c;

  logic [WIDTH-1:0] c_d;
  logic             zero_d;
  logic             neg_d;
  logic             par_d;
  logic             out_valid_d;

  // Next-state for the result registers. Without a valid operand the flags
  // and data hold their last value while the strobe drops, so a consumer
  // can still read the previous result after out_valid falls.
  always_comb begin
    c_d         = c_q;
    zero_d      = zero_q;
    neg_d       = neg_q;
    par_d       = par_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      c_d         = c;
      zero_d      = zero;
      neg_d       = c[WIDTH-1];
      par_d       = ^c;
      out_valid_d = 1'b1;
    end
  end

  // Result registers. Reset wins over in_valid, so a result that is in
  // flight when reset arrives is discarded rather than presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_q       <= '0;
      zero_q    <= 1'b0;
      neg_q     <= 1'b0;
      par_q     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      c_q       <= c_d;
      zero_q    <= zero_d;
      neg_q     <= neg_d;
      par_q     <= par_d;
      out_valid <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_not_ops.sv
// ---------------------------------------------------------------------------
// tb_not_ops
//   Self-checking bench for not_ops at the default width of 20 bits.
//   A table of directed vectors walks the datapath corners, then a seeded
//   random run is compared against a behavioural reference model.
// ---------------------------------------------------------------------------
module tb_not_ops;

  localparam int W = 20;
  localparam logic [W-1:0] ALL_ONES = 20'hFFFFF;

  logic         clk;
  logic         rst;
  logic [W-1:0] a;
  logic         in_valid;
  logic [W-1:0] c;
  logic         zero;
  logic [W-1:0] c_q;
  logic         zero_q;
  logic         neg_q;
  logic         par_q;
  logic         out_valid;

  int checks;
  int errors;

  not_ops #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .in_valid  (in_valid),
    .c         (c),
    .zero      (zero),
    .c_q       (c_q),
    .zero_q    (zero_q),
    .neg_q     (neg_q),
    .par_q     (par_q),
    .out_valid (out_valid)
  );

  // Free-running 10 time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One directed vector: inputs for a cycle plus the combinational
  // outputs expected during it and the registered outputs expected after
  // the following rising edge.
  typedef struct {
    logic         rst;
    logic         inValid;
    logic [W-1:0] a;
    logic [W-1:0] expC;
    logic         expZero;
    logic [W-1:0] expCq;
    logic         expZeroQ;
    logic         expNegQ;
    logic         expParQ;
    logic         expValid;
  } vec_t;

  vec_t vecs[8];

  // Reference model state for the registered outputs.
  logic [W-1:0] refCq;
  logic         refZeroQ;
  logic         refNegQ;
  logic         refParQ;
  logic         refValid;

  // Complement by subtraction from the all-ones value.
  function automatic logic [W-1:0] modelNot(input logic [W-1:0] x);
    return ALL_ONES - x;
  endfunction

  // Parity by counting set bits.
  function automatic logic modelPar(input logic [W-1:0] x);
    int ones;
    ones = 0;
    for (int i = 0; i < W; i++) ones += int'(x[i]);
    return (ones % 2) == 1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, check the combinational path, then step the
  // clock and advance the model.
  task automatic applyStimulus(input logic r, input logic v,
                               input logic [W-1:0] x);
    logic [W-1:0] expC;
    rst      = r;
    in_valid = v;
    a        = x;
    #1;
    expC = modelNot(x);
    checkOutput("c", 32'(c), 32'(expC));
    checkOutput("zero", 32'(zero), 32'(x == ALL_ONES));
    @(posedge clk);
    if (r) begin
      refCq = '0; refZeroQ = 1'b0; refNegQ = 1'b0; refParQ = 1'b0;
      refValid = 1'b0;
    end else if (v) begin
      refCq    = expC;
      refZeroQ = (expC == 0);
      refNegQ  = (expC >= 20'h80000);
      refParQ  = modelPar(expC);
      refValid = 1'b1;
    end else begin
      refValid = 1'b0;
    end
    #1;
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, " c_q"}, 32'(c_q), 32'(refCq));
    checkOutput({tag, " zero_q"}, 32'(zero_q), 32'(refZeroQ));
    checkOutput({tag, " neg_q"}, 32'(neg_q), 32'(refNegQ));
    checkOutput({tag, " par_q"}, 32'(par_q), 32'(refParQ));
    checkOutput({tag, " out_valid"}, 32'(out_valid), 32'(refValid));
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    refCq = '0; refZeroQ = 1'b0; refNegQ = 1'b0; refParQ = 1'b0;
    refValid = 1'b0;

    //        rst   vld   a          c          z     c_q        zq    nq    pq    ov
    vecs[0] = '{1'b1, 1'b1, 20'h00000, 20'hFFFFF, 1'b0, 20'h00000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 20'h00000, 20'hFFFFF, 1'b0, 20'hFFFFF, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 20'hFFFFF, 20'h00000, 1'b1, 20'h00000, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 20'hA5A5A, 20'h5A5A5, 1'b0, 20'h5A5A5, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 20'h12345, 20'hEDCBA, 1'b0, 20'hEDCBA, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 20'h00F0F, 20'hFF0F0, 1'b0, 20'hEDCBA, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 20'h00001, 20'hFFFFE, 1'b0, 20'h00000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 20'h80000, 20'h7FFFF, 1'b0, 20'h7FFFF, 1'b0, 1'b0, 1'b1, 1'b1};

    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      rst      = vecs[i].rst;
      in_valid = vecs[i].inValid;
      a        = vecs[i].a;
      #1;
      checkOutput($sformatf("vec%0d c", i), 32'(c), 32'(vecs[i].expC));
      checkOutput($sformatf("vec%0d zero", i), 32'(zero), 32'(vecs[i].expZero));
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d c_q", i), 32'(c_q), 32'(vecs[i].expCq));
      checkOutput($sformatf("vec%0d zero_q", i), 32'(zero_q), 32'(vecs[i].expZeroQ));
      checkOutput($sformatf("vec%0d neg_q", i), 32'(neg_q), 32'(vecs[i].expNegQ));
      checkOutput($sformatf("vec%0d par_q", i), 32'(par_q), 32'(vecs[i].expParQ));
      checkOutput($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].expValid));
    end

    // Resynchronise the model with the last table row.
    refCq = 20'h7FFFF; refZeroQ = 1'b0; refNegQ = 1'b0; refParQ = 1'b1;
    refValid = 1'b1;

    // Hold across several idle cycles, then reset with idle input and a
    // valid arriving right as reset releases.
    applyStimulus(1'b0, 1'b0, 20'h13579); checkModel("idle1");
    applyStimulus(1'b0, 1'b0, 20'hFFFFF); checkModel("idle2");
    applyStimulus(1'b1, 1'b0, 20'h00000); checkModel("rstIdle");
    applyStimulus(1'b0, 1'b1, 20'hFFFFF); checkModel("postRst");

    // Seeded random run against the reference model.
    void'($urandom(32'd20240611));
    for (int i = 0; i < 60; i++) begin
      logic [W-1:0] x;
      logic r;
      logic v;
      x = W'($urandom);
      if (($urandom % 8) == 0) x = ALL_ONES;
      r = (($urandom % 12) == 0);
      v = (($urandom % 4) != 0);
      applyStimulus(r, v, x);
      checkModel($sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
